alu_sweep_sequencer: RTL and testbench

//   Drives the registered ALU timing wrapper from the initiator side.
//   On start, latches one operand pair and sweeps alu_sel through opcodes 0..NUM_OPS-1.
//   For each opcode it waits the wrapper latency, then captures result and flags into an

---
 rtl/alu_sweep_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_sweep_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sweep_sequencer.sv
// alu_sweep_sequencer
// Drives a registered ALU wrapper through opcodes 0..NUM_OPS-1 using one latched
// operand pair, waits the wrapper latency for each opcode, and stores result plus
// flags into a small result buffer that can be read combinationally by index.
module alu_sweep_sequencer #(
  parameter int N       = 5,
  parameter int NUM_OPS = 10,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [N-1:0] alu_out,
  input  logic         alu_z,
  input  logic         alu_o,
  input  logic         alu_ca,
  input  logic         alu_neg,
  input  logic [3:0]   rd_idx,
  output logic [N+3:0] rd_data
);

  localparam int WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WCW-1:0] WCNT_LAST = WCW'(LATENCY - 1);
  localparam logic [3:0]     SEL_LAST  = 4'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   a_reg, b_reg;
  logic [3:0]     sel_reg;
  logic [WCW-1:0] wcnt_reg;
  logic [N+3:0]   capture_word;

  // Every buffer slot is exposed here; slots beyond NUM_OPS are tied to zero so
  // any 4-bit read index lands on a defined value.
  logic [N+3:0]   buf_mem [16];

  assign capture_word = {alu_neg, alu_ca, alu_o, alu_z, alu_out};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; start is only honoured in IDLE, so DONE also ignores it
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = WAIT;
      WAIT:    if (wcnt_reg == WCNT_LAST) state_next = CAPTURE;
      CAPTURE: state_next = (sel_reg == SEL_LAST) ? DONE : WAIT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      IDLE:    busy = 1'b0;
      WAIT:    busy = 1'b1;
      CAPTURE: busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

  // Operand latch, opcode stepping and wait counter; opcode only moves when
  // leaving CAPTURE so the wrapper inputs stay stable across each wait window
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sel_reg  <= '0;
      wcnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg    <= a_in;
            b_reg    <= b_in;
            sel_reg  <= '0;
            wcnt_reg <= '0;
          end
        end
        WAIT: wcnt_reg <= wcnt_reg + WCW'(1);
        CAPTURE: begin
          if (sel_reg != SEL_LAST) begin
            sel_reg  <= sel_reg + 4'd1;
            wcnt_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Result buffer: one register per swept opcode, cleared by reset and written
  // only in the CAPTURE cycle for its own opcode
  for (genvar gi = 0; gi < 16; gi++) begin : g_buf
    if (gi < NUM_OPS) begin : g_live
      logic [N+3:0] entry_reg;
      // Capture this opcode's result and flags
      always_ff @(posedge clk) begin
        if (rst)
          entry_reg <= '0;
        else if (state_reg == CAPTURE && sel_reg == 4'(gi))
          entry_reg <= capture_word;
      end
      assign buf_mem[gi] = entry_reg;
    end else begin : g_zero
      assign buf_mem[gi] = '0;
    end
  end

  assign rd_data = buf_mem[rd_idx];
  assign alu_a   = a_reg;
  assign alu_b   = b_reg;
  assign alu_sel = sel_reg;

endmodule

// File: tb/tb_alu_sweep_sequencer.sv
// Bench for alu_sweep_sequencer: two instances (LATENCY=2 and LATENCY=1) share
// stimulus, each behind its own behavioural ALU delay line.
module tb_alu_sweep_sequencer;

  localparam int N    = 5;
  localparam int NOPS = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a_in = '0;
  logic [N-1:0] b_in = '0;
  logic [3:0]   rd_idx = '0;

  logic         busy2, done2, z2, o2, ca2, neg2;
  logic [N-1:0] alu_a2, alu_b2, out2;
  logic [3:0]   sel2;
  logic [N+3:0] rd2;

  logic         busy1, done1, z1, o1, ca1, neg1;
  logic [N-1:0] alu_a1, alu_b1, out1;
  logic [3:0]   sel1;
  logic [N+3:0] rd1;

  alu_sweep_sequencer #(.N(N), .NUM_OPS(NOPS), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy2), .done(done2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_sel(sel2),
    .alu_out(out2), .alu_z(z2), .alu_o(o2), .alu_ca(ca2), .alu_neg(neg2),
    .rd_idx(rd_idx), .rd_data(rd2)
  );

  alu_sweep_sequencer #(.N(N), .NUM_OPS(NOPS), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy1), .done(done1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(sel1),
    .alu_out(out1), .alu_z(z1), .alu_o(o1), .alu_ca(ca1), .alu_neg(neg1),
    .rd_idx(rd_idx), .rd_data(rd1)
  );

  // Behavioural ALU: sel0 = A+B, sel1 = A-B (carry = borrow), others all zero.
  // Returned as {neg, ca, o, z, out}.
  function automatic logic [8:0] alu_fn(input logic [4:0] a, input logic [4:0] b,
                                        input logic [3:0] sel);
    logic [5:0] s;
    logic [4:0] r;
    logic       c, o;
    if (sel == 4'd0) begin
      s = {1'b0, a} + {1'b0, b};
      r = s[4:0];
      c = s[5];
      o = (a[4] == b[4]) && (r[4] != a[4]);
    end else if (sel == 4'd1) begin
      r = a - b;
      c = (a < b);
      o = (a[4] != b[4]) && (r[4] != a[4]);
    end else begin
      return 9'd0;
    end
    return {r[4], c, o, (r == 5'd0), r};
  endfunction

  // LATENCY=2 wrapper model
  logic [8:0] p2_0 = '0, p2_1 = '0;
  always @(posedge clk) begin
    p2_0 <= alu_fn(alu_a2, alu_b2, sel2);
    p2_1 <= p2_0;
  end
  assign {neg2, ca2, o2, z2, out2} = p2_1;

  // LATENCY=1 wrapper model
  logic [8:0] p1_0 = '0;
  always @(posedge clk) p1_0 <= alu_fn(alu_a1, alu_b1, sel1);
  assign {neg1, ca1, o1, z1, out1} = p1_0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    int         p1;
    int         p2;
    logic [8:0] e0;
    logic [8:0] e1;
  } vec_t;

  vec_t       vecs [6];
  logic [8:0] sb_q [$];

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      chk($sformatf("%s_rd2[%0d]", tag, i), 32'(rd2), 32'd0);
      chk($sformatf("%s_rd1[%0d]", tag, i), 32'(rd1), 32'd0);
    end
  endtask

  // One full sweep; extra start pulses (with different operands) at edge counts p1/p2
  task automatic run_sweep(input int vi);
    vec_t v;
    int   edges, d2, d1, nd2, nd1, es2, es1;
    logic [8:0] exp;
    v = vecs[vi];
    a_in  = v.a;
    b_in  = v.b;
    start = 1'b1;
    for (int i = 0; i < 16; i++)
      sb_q.push_back(i == 0 ? v.e0 : (i == 1 ? v.e1 : 9'd0));
    tick();
    start = 1'b0;
    edges = 1; d2 = 0; d1 = 0; nd2 = 0; nd1 = 0;
    chk($sformatf("v%0d_busy2_first", vi), 32'(busy2), 32'd1);
    chk($sformatf("v%0d_busy1_first", vi), 32'(busy1), 32'd1);
    while (edges < 40) begin
      if (done2) begin nd2++; if (d2 == 0) d2 = edges; end
      if (done1) begin nd1++; if (d1 == 0) d1 = edges; end
      es2 = (edges - 1) / 3; if (es2 > NOPS - 1) es2 = NOPS - 1;
      es1 = (edges - 1) / 2; if (es1 > NOPS - 1) es1 = NOPS - 1;
      chk($sformatf("v%0d_sel2_e%0d", vi, edges), 32'(sel2), 32'(es2));
      chk($sformatf("v%0d_sel1_e%0d", vi, edges), 32'(sel1), 32'(es1));
      chk($sformatf("v%0d_alu_a2_e%0d", vi, edges), 32'(alu_a2), 32'(v.a));
      chk($sformatf("v%0d_alu_b1_e%0d", vi, edges), 32'(alu_b1), 32'(v.b));
      if (edges == v.p1 || edges == v.p2) begin
        start = 1'b1;
        a_in  = ~v.a;
        b_in  = ~v.b;
      end else begin
        start = 1'b0;
        a_in  = v.a;
        b_in  = v.b;
      end
      tick();
      edges++;
    end
    start = 1'b0;
    chk($sformatf("v%0d_done_at_l2", vi), 32'(d2), 32'd31);
    chk($sformatf("v%0d_done_at_l1", vi), 32'(d1), 32'd21);
    chk($sformatf("v%0d_done_pulses_l2", vi), 32'(nd2), 32'd1);
    chk($sformatf("v%0d_done_pulses_l1", vi), 32'(nd1), 32'd1);
    chk($sformatf("v%0d_idle_busy2", vi), 32'(busy2), 32'd0);
    for (int i = 0; i < 16; i++) begin
      exp = sb_q.pop_front();
      rd_idx = 4'(i);
      #1;
      $display("sweep v%0d a=%0d b=%0d idx=%0d rd_l2=%03h rd_l1=%03h exp=%03h",
               vi, v.a, v.b, i, rd2, rd1, exp);
      chk($sformatf("v%0d_buf_l2[%0d]", vi, i), 32'(rd2), 32'(exp));
      chk($sformatf("v%0d_buf_l1[%0d]", vi, i), 32'(rd1), 32'(exp));
    end
  endtask

  initial begin
    vecs[0] = '{a: 5'd7,  b: 5'd3, p1: -1, p2: -1, e0: 9'h00A, e1: 9'h004};
    vecs[1] = '{a: 5'd5,  b: 5'd5, p1: -1, p2: -1, e0: 9'h00A, e1: 9'h020};
    vecs[2] = '{a: 5'd0,  b: 5'd1, p1: -1, p2: -1, e0: 9'h001, e1: 9'h19F};
    vecs[3] = '{a: 5'd7,  b: 5'd3, p1: 5,  p2: 20, e0: 9'h00A, e1: 9'h004};
    vecs[4] = '{a: 5'd12, b: 5'd9, p1: -1, p2: -1, e0: 9'h155, e1: 9'h003};
    vecs[5] = '{a: 5'd31, b: 5'd1, p1: -1, p2: -1, e0: 9'h0A0, e1: 9'h11E};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_done2", 32'(done2), 32'd0);
    chk("rst_sel2", 32'(sel2), 32'd0);
    chk("rst_alu_a2", 32'(alu_a2), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    check_all_zero("rst");

    // Table-driven sweeps
    for (int vi = 0; vi < 6; vi++) run_sweep(vi);

    // Partial overwrite: after four edges of a new sweep only entry 0 is fresh
    a_in = 5'd0; b_in = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rd_idx = 4'd0; #1;
    chk("partial_l2_idx0", 32'(rd2), 32'h001);
    chk("partial_l1_idx0", 32'(rd1), 32'h001);
    rd_idx = 4'd1; #1;
    chk("partial_l2_idx1_old", 32'(rd2), 32'h11E);
    chk("partial_l1_idx1_old", 32'(rd1), 32'h11E);
    $display("partial sweep idx1 l2=%03h l1=%03h", rd2, rd1);

    // Abort with reset in cycle 12, start held high to show reset wins
    for (int i = 4; i < 12; i++) tick();
    chk("pre_abort_busy2", 32'(busy2), 32'd1);
    rst = 1'b1; start = 1'b1;
    tick();
    chk("abort_busy2", 32'(busy2), 32'd0);
    chk("abort_busy1", 32'(busy1), 32'd0);
    chk("abort_done2", 32'(done2), 32'd0);
    chk("abort_sel2", 32'(sel2), 32'd0);
    chk("abort_alu_a2", 32'(alu_a2), 32'd0);
    check_all_zero("abort");
    rst = 1'b0; start = 1'b0;
    tick();
    chk("post_abort_idle2", 32'(busy2), 32'd0);
    $display("abort with reset: busy l2=%0d l1=%0d", busy2, busy1);

    // Recovery sweep after abort
    run_sweep(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
